// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that shares one I2C master engine among NUM_REQ requesters,
// running one register transaction at a time under a per-phase watchdog.
module i2c_arbiter #(
   parameter int                   NUM_REQ        = 2,
   parameter int                   TIMEOUT_W      = 24,
   parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = TIMEOUT_W'(1_000_000)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [NUM_REQ-1:0]     req_is_read,
   input  logic [7*NUM_REQ-1:0]   req_chip_addr,
   input  logic [8*NUM_REQ-1:0]   req_reg_addr,
   input  logic [8*NUM_REQ-1:0]   req_value,
   output logic [NUM_REQ-1:0]     grant,
   output logic [NUM_REQ-1:0]     ack,
   output logic [7:0]             rsp_data,
   output logic                   rsp_error,
   output logic                   rsp_timeout,
   output logic                   busy,
   output logic [6:0]             i2c_chip_addr,
   output logic [7:0]             i2c_reg_addr,
   output logic [7:0]             i2c_value,
   output logic                   i2c_is_read,
   output logic                   i2c_enable,
   input  logic [7:0]             i2c_data,
   input  logic                   i2c_done,
   input  logic                   i2c_ack_error
);

   localparam int RR_W = (NUM_REQ > 2) ? 2 : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state_q, state_n;
   logic [RR_W-1:0]       rr_q, rr_n;
   logic [TIMEOUT_W-1:0]  wdog_q, wdog_n, wdog_inc;

   logic [NUM_REQ-1:0]    grant_n, ack_n;
   logic [7:0]            rsp_data_n;
   logic                  rsp_error_n, rsp_timeout_n;
   logic [6:0]            i2c_chip_addr_n;
   logic [7:0]            i2c_reg_addr_n, i2c_value_n;
   logic                  i2c_is_read_n, i2c_enable_n;

   logic [NUM_REQ-1:0]    req_rot;
   logic [RR_W-1:0]       win_pos, win_idx;
   logic [RR_W:0]         win_sum;
   logic                  win_found;
   logic [6:0]            sel_chip;
   logic [7:0]            sel_reg, sel_value;
   logic                  sel_read;
   logic [NUM_REQ-1:0]    sel_onehot;

   // Rotate the request vector so bit 0 is the requester at rr, then take the
   // lowest set bit and map it back to an absolute requester index.
   always_comb begin
      req_rot   = NUM_REQ'({req, req} >> rr_q);
      win_found = 1'b0;
      win_pos   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) begin
            win_found = 1'b1;
            win_pos   = RR_W'(k);
         end
      end
      win_sum = {1'b0, rr_q} + {1'b0, win_pos};
      if (win_sum >= (RR_W+1)'(NUM_REQ))
         win_sum = win_sum - (RR_W+1)'(NUM_REQ);
      win_idx = win_sum[RR_W-1:0];
   end

   always_comb begin
      sel_chip   = '0;
      sel_reg    = '0;
      sel_value  = '0;
      sel_read   = 1'b0;
      sel_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == RR_W'(i)) begin
            sel_chip      = req_chip_addr[7*i +: 7];
            sel_reg       = req_reg_addr[8*i +: 8];
            sel_value     = req_value[8*i +: 8];
            sel_read      = req_is_read[i];
            sel_onehot[i] = 1'b1;
         end
      end
   end

   assign wdog_inc = wdog_q + TIMEOUT_W'(1);

   // Next-state and registered-output logic; everything holds unless a state acts.
   always_comb begin
      state_n         = state_q;
      rr_n            = rr_q;
      wdog_n          = wdog_q;
      grant_n         = grant;
      ack_n           = '0;
      rsp_data_n      = rsp_data;
      rsp_error_n     = rsp_error;
      rsp_timeout_n   = rsp_timeout;
      i2c_chip_addr_n = i2c_chip_addr;
      i2c_reg_addr_n  = i2c_reg_addr;
      i2c_value_n     = i2c_value;
      i2c_is_read_n   = i2c_is_read;
      i2c_enable_n    = i2c_enable;

      case (state_q)
         S_IDLE: begin
            if (i2c_done && win_found) begin
               i2c_chip_addr_n = sel_chip;
               i2c_reg_addr_n  = sel_reg;
               i2c_value_n     = sel_value;
               i2c_is_read_n   = sel_read;
               i2c_enable_n    = 1'b1;
               grant_n         = sel_onehot;
               rr_n            = (win_idx == RR_W'(NUM_REQ - 1)) ? '0 : win_idx + RR_W'(1);
               wdog_n          = '0;
               state_n         = S_START;
            end
         end

         S_START: begin
            if (!i2c_done) begin
               i2c_enable_n = 1'b0;
               wdog_n       = '0;
               state_n      = S_RUN;
            end else if (wdog_inc == TIMEOUT_CYCLES) begin
               wdog_n        = wdog_inc;
               i2c_enable_n  = 1'b0;
               rsp_error_n   = 1'b1;
               rsp_timeout_n = 1'b1;
               ack_n         = grant;
               state_n       = S_DONE;
            end else begin
               wdog_n = wdog_inc;
            end
         end

         S_RUN: begin
            if (i2c_done) begin
               if (i2c_is_read)
                  rsp_data_n = i2c_data;
               rsp_error_n   = i2c_ack_error;
               rsp_timeout_n = 1'b0;
               ack_n         = grant;
               state_n       = S_DONE;
            end else if (wdog_inc == TIMEOUT_CYCLES) begin
               wdog_n        = wdog_inc;
               i2c_enable_n  = 1'b0;
               rsp_error_n   = 1'b1;
               rsp_timeout_n = 1'b1;
               ack_n         = grant;
               state_n       = S_DONE;
            end else begin
               wdog_n = wdog_inc;
            end
         end

         S_DONE: begin
            grant_n = '0;
            state_n = S_IDLE;
         end

         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         rr_q          <= '0;
         wdog_q        <= '0;
         grant         <= '0;
         ack           <= '0;
         rsp_data      <= '0;
         rsp_error     <= 1'b0;
         rsp_timeout   <= 1'b0;
         i2c_chip_addr <= '0;
         i2c_reg_addr  <= '0;
         i2c_value     <= '0;
         i2c_is_read   <= 1'b0;
         i2c_enable    <= 1'b0;
      end else begin
         state_q       <= state_n;
         rr_q          <= rr_n;
         wdog_q        <= wdog_n;
         grant         <= grant_n;
         ack           <= ack_n;
         rsp_data      <= rsp_data_n;
         rsp_error     <= rsp_error_n;
         rsp_timeout   <= rsp_timeout_n;
         i2c_chip_addr <= i2c_chip_addr_n;
         i2c_reg_addr  <= i2c_reg_addr_n;
         i2c_value     <= i2c_value_n;
         i2c_is_read   <= i2c_is_read_n;
         i2c_enable    <= i2c_enable_n;
      end
   end

   assign busy = (state_q != S_IDLE);

endmodule
